// File: rtl/hex_led_pkg.sv
// Shared register map, CTRL layout and seven-segment decode for the HPS display peripheral.
// Bit order of every segment pattern is g..a (bit 0 = a); segments are active-low.
package hex_led_pkg;

    localparam logic [1:0] ADDR_CTRL  = 2'd0;
    localparam logic [1:0] ADDR_VALUE = 2'd1;
    localparam logic [1:0] ADDR_LEDS  = 2'd2;
    localparam logic [1:0] ADDR_DIV   = 2'd3;

    localparam int CTRL_ENABLE      = 0;
    localparam int CTRL_COUNT_EN    = 1;
    localparam int CTRL_COUNT_DOWN  = 2;
    localparam int CTRL_BLINK_EN    = 3;
    localparam int CTRL_LZ_SUPPRESS = 4;
    localparam int CTRL_WIDTH       = 5;

    // Field order mirrors the CTRL bit positions so a 5-bit slice casts directly.
    typedef struct packed {
        logic lz_suppress;
        logic blink_en;
        logic count_down;
        logic count_en;
        logic enable;
    } ctrl_t;

    function automatic logic [6:0] seg7_lut(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/hex_led_prescaler.sv
// Programmable tick generator: counts 0..div while enabled and pulses tick_o on the
// terminal count. Owns the divider register so a divider write can restart the count.
module hex_led_prescaler #(
    parameter logic [31:0] DIV_RESET = 32'd49_999_999
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable_i,
    input  logic        div_we_i,
    input  logic [31:0] div_wdata_i,
    output logic [31:0] div_o,
    output logic        tick_o
);

    logic [31:0] div_q, div_d;
    logic [31:0] cnt_q, cnt_d;

    assign tick_o = enable_i && (cnt_q == div_q);
    assign div_o  = div_q;

    // A divider write restarts the period so the first tick after it is a full one.
    always_comb begin
        div_d = div_q;
        cnt_d = cnt_q;
        if (div_we_i) begin
            div_d = div_wdata_i;
            cnt_d = '0;
        end else if (!enable_i || tick_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= DIV_RESET;
            cnt_q <= '0;
        end else begin
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hex_led_periph.sv
// Avalon-MM display peripheral: NUM_DIGITS hex digits plus an LED bank, with auto-count,
// blink and leading-zero suppression. Outputs are registered one stage after register state.
module hex_led_periph
    import hex_led_pkg::*;
#(
    parameter int          NUM_DIGITS = 6,
    parameter int          NUM_LEDS   = 8,
    parameter logic [31:0] DIV_RESET  = 32'(50_000_000 - 1)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [1:0]              avs_address,
    input  logic                    avs_read,
    output logic [31:0]             avs_readdata,
    input  logic                    avs_write,
    input  logic [31:0]             avs_writedata,
    output logic [7*NUM_DIGITS-1:0] hex_n,
    output logic [NUM_LEDS-1:0]     leds
);

    localparam int             VW  = 4 * NUM_DIGITS;
    localparam logic [VW-1:0]  ONE = {{(VW-1){1'b0}}, 1'b1};

    ctrl_t                   ctrl_q, ctrl_d;
    logic [VW-1:0]           value_q, value_d;
    logic [NUM_LEDS-1:0]     leds_q, leds_d;
    logic                    phase_q, phase_d;
    logic [31:0]             rdata_q, rdata_d;
    logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
    logic [NUM_LEDS-1:0]     ledo_q, ledo_d;

    logic        wr_ctrl, wr_value, wr_leds, wr_div;
    logic        tick;
    logic [31:0] div_val;
    logic [31:0] rd_mux;
    logic [3:0]  nib;
    logic        nz_above;

    assign wr_ctrl  = avs_write && (avs_address == ADDR_CTRL);
    assign wr_value = avs_write && (avs_address == ADDR_VALUE);
    assign wr_leds  = avs_write && (avs_address == ADDR_LEDS);
    assign wr_div   = avs_write && (avs_address == ADDR_DIV);

    hex_led_prescaler #(
        .DIV_RESET (DIV_RESET)
    ) u_prescaler (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable_i    (ctrl_q.enable),
        .div_we_i    (wr_div),
        .div_wdata_i (avs_writedata),
        .div_o       (div_val),
        .tick_o      (tick)
    );

    // Register updates; a bus write to VALUE overrides a coincident count step.
    always_comb begin
        ctrl_d  = ctrl_q;
        value_d = value_q;
        leds_d  = leds_q;
        phase_d = phase_q;
        if (tick && ctrl_q.blink_en) begin
            phase_d = ~phase_q;
        end
        if (wr_ctrl) begin
            ctrl_d = ctrl_t'(avs_writedata[CTRL_WIDTH-1:0]);
            if (!avs_writedata[CTRL_BLINK_EN]) begin
                phase_d = 1'b0;
            end
        end
        if (wr_value) begin
            value_d = avs_writedata[VW-1:0];
        end else if (tick && ctrl_q.count_en) begin
            value_d = ctrl_q.count_down ? (value_q - ONE) : (value_q + ONE);
        end
        if (wr_leds) begin
            leds_d = avs_writedata[NUM_LEDS-1:0];
        end
    end

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            ADDR_CTRL: begin
                rd_mux[CTRL_ENABLE]      = ctrl_q.enable;
                rd_mux[CTRL_COUNT_EN]    = ctrl_q.count_en;
                rd_mux[CTRL_COUNT_DOWN]  = ctrl_q.count_down;
                rd_mux[CTRL_BLINK_EN]    = ctrl_q.blink_en;
                rd_mux[CTRL_LZ_SUPPRESS] = ctrl_q.lz_suppress;
            end
            ADDR_VALUE: rd_mux[VW-1:0]       = value_q;
            ADDR_LEDS:  rd_mux[NUM_LEDS-1:0] = leds_q;
            default:    rd_mux               = div_val;
        endcase
        rdata_d = avs_read ? rd_mux : rdata_q;
    end

    // Walk digits from the most significant down, tracking whether anything nonzero has been seen.
    always_comb begin
        hex_d    = '1;
        nib      = 4'h0;
        nz_above = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            nib      = value_q[4*k +: 4];
            nz_above = nz_above | (nib != 4'h0);
            if (ctrl_q.lz_suppress && !nz_above && (k != 0)) begin
                hex_d[7*k +: 7] = 7'h7F;
            end else begin
                hex_d[7*k +: 7] = seg7_lut(nib);
            end
        end
        if (!ctrl_q.enable || (ctrl_q.blink_en && phase_q)) begin
            hex_d = '1;
        end
        ledo_d = ctrl_q.enable ? leds_q : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q  <= '0;
            value_q <= '0;
            leds_q  <= '0;
            phase_q <= 1'b0;
            rdata_q <= '0;
            hex_q   <= '1;
            ledo_q  <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            value_q <= value_d;
            leds_q  <= leds_d;
            phase_q <= phase_d;
            rdata_q <= rdata_d;
            hex_q   <= hex_d;
            ledo_q  <= ledo_d;
        end
    end

    assign avs_readdata = rdata_q;
    assign hex_n        = hex_q;
    assign leds         = ledo_q;

endmodule

// File: tb/tb_hex_led_periph.sv
// Directed bench for hex_led_periph: a register-level reference model is checked against the
// DUT on every falling edge, with hand-computed literal checks pinning key scenarios.
module tb_hex_led_periph;

    localparam int          ND    = 6;
    localparam int          NL    = 8;
    localparam logic [31:0] DIVR  = 32'h02FA_F07F;
    localparam logic [31:0] VMASK = 32'h00FF_FFFF;
    localparam logic [41:0] ALL1  = '1;
    localparam logic [6:0]  SEG_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [1:0]    avs_address;
    logic          avs_read;
    logic [31:0]   avs_readdata;
    logic          avs_write;
    logic [31:0]   avs_writedata;
    logic [41:0]   hex_n;
    logic [NL-1:0] leds;

    int errors = 0;
    int checks = 0;

    hex_led_periph #(
        .NUM_DIGITS (ND),
        .NUM_LEDS   (NL),
        .DIV_RESET  (DIVR)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_readdata  (avs_readdata),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .hex_n         (hex_n),
        .leds          (leds)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: register contents plus what the outputs should show.
    logic [31:0] m_ctrl, m_value, m_leds, m_div, m_cnt, m_rd;
    logic        m_phase, m_tick;
    logic [41:0] m_hex;
    logic [7:0]  m_ledo;

    function automatic logic [41:0] disp(input logic [31:0] c, input logic [31:0] v, input logic ph);
        logic [41:0] r;
        int nib;
        r = '1;
        if (c[0] && !(c[3] && ph)) begin
            for (int k = 0; k < ND; k++) begin
                nib = int'((v >> (4 * k)) & 32'hF);
                if (c[4] && k > 0 && (v >> (4 * k)) == 32'd0) r[7*k +: 7] = 7'h7F;
                else r[7*k +: 7] = SEG_TAB[nib];
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] reg_read(input logic [1:0] a);
        case (a)
            2'd0:    return m_ctrl;
            2'd1:    return m_value;
            2'd2:    return m_leds;
            default: return m_div;
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_ctrl = 0; m_value = 0; m_leds = 0; m_div = DIVR; m_cnt = 0;
            m_phase = 1'b0; m_hex = ALL1; m_ledo = 8'h00; m_rd = 0;
        end else begin
            m_tick = m_ctrl[0] && (m_cnt == m_div);
            m_hex  = disp(m_ctrl, m_value, m_phase);
            m_ledo = m_ctrl[0] ? m_leds[7:0] : 8'h00;
            if (avs_read) m_rd = reg_read(avs_address);
            if (avs_write && avs_address == 2'd0 && !avs_writedata[3]) m_phase = 1'b0;
            else if (m_tick && m_ctrl[3]) m_phase = !m_phase;
            if (avs_write && avs_address == 2'd1) m_value = avs_writedata & VMASK;
            else if (m_tick && m_ctrl[1])
                m_value = m_ctrl[2] ? ((m_value + VMASK) & VMASK) : ((m_value + 1) & VMASK);
            if (avs_write && avs_address == 2'd3) m_cnt = 0;
            else if (!m_ctrl[0] || m_tick) m_cnt = 0;
            else m_cnt = m_cnt + 1;
            if (avs_write && avs_address == 2'd0) m_ctrl = avs_writedata & 32'h1F;
            if (avs_write && avs_address == 2'd2) m_leds = avs_writedata & 32'hFF;
            if (avs_write && avs_address == 2'd3) m_div = avs_writedata;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            check("hex_n", hex_n, m_hex);
            check("leds", leds, m_ledo);
            check("readdata", avs_readdata, m_rd);
        end
    end

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        avs_address = a; avs_read = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    logic [31:0] d;

    initial begin
        avs_address = 2'd0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_hex", hex_n, ALL1);
        check("rst_leds", leds, 8'h00);
        check("rst_rdata", avs_readdata, 32'd0);
        reset_n = 1'b1;
        rd(2'd3, d);  check("div_reset", d, 32'h02FAF07F);
        rd(2'd1, d);  check("value_reset", d, 32'd0);

        wr(2'd2, 32'hA5);
        wr(2'd0, 32'h01);
        @(negedge clk);
        check("leds_a5", leds, 8'hA5);
        check("hex_zero", hex_n, {6{7'b1000000}});

        wr(2'd0, 32'h00);
        wr(2'd3, 32'd3);
        wr(2'd1, 32'h0E);
        wr(2'd0, 32'h03);
        repeat (4) @(negedge clk);
        rd(2'd1, d);  check("count_0f", d, 32'h0F);
        repeat (3) @(negedge clk);
        rd(2'd1, d);  check("count_10", d, 32'h10);

        wr(2'd0, 32'h00);
        wr(2'd1, 32'h00);
        wr(2'd0, 32'h07);
        repeat (4) @(negedge clk);
        rd(2'd1, d);  check("down_wrap", d, 32'hFFFFFF);
        rd(2'd0, d);  check("ctrl_rb", d, 32'h07);

        wr(2'd0, 32'h00);
        wr(2'd1, 32'hFFFFFF);
        wr(2'd0, 32'h03);
        repeat (4) @(negedge clk);
        rd(2'd1, d);  check("up_wrap", d, 32'h0);

        wr(2'd0, 32'h00);
        wr(2'd1, 32'h42);
        avs_address = 2'd1; avs_writedata = 32'h77; avs_write = 1'b1; avs_read = 1'b1;
        @(negedge clk);
        avs_write = 1'b0; avs_read = 1'b0;
        check("rw_old", avs_readdata, 32'h42);
        rd(2'd1, d);  check("rw_new", d, 32'h77);
        wr(2'd1, 32'hFF12_3456);
        rd(2'd1, d);  check("value_mask", d, 32'h123456);

        wr(2'd1, 32'h120);
        wr(2'd0, 32'h11);
        @(negedge clk);
        check("lz_hex", hex_n, {7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h40});
        rd(2'd0, d);  check("ctrl_lz", d, 32'h11);

        wr(2'd3, 32'd0);
        wr(2'd0, 32'h09);
        @(negedge clk);
        check("blink_on", hex_n, {7'h40, 7'h40, 7'h40, 7'h79, 7'h24, 7'h40});
        check("blink_leds0", leds, 8'hA5);
        @(negedge clk);
        check("blink_off", hex_n, ALL1);
        check("blink_leds1", leds, 8'hA5);
        repeat (6) @(negedge clk);
        wr(2'd0, 32'h01);
        repeat (3) @(negedge clk);

        wr(2'd0, 32'h00);
        wr(2'd3, 32'd3);
        wr(2'd0, 32'h03);
        repeat (7) @(negedge clk);
        wr(2'd1, 32'h55);
        rd(2'd1, d);  check("write_wins", d, 32'h55);

        repeat (2) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_hex", hex_n, ALL1);
        check("arst_leds", leds, 8'h00);
        check("arst_rdata", avs_readdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        rd(2'd3, d);  check("div_after_rst", d, DIVR);
        rd(2'd1, d);  check("value_after_rst", d, 32'd0);
        rd(2'd0, d);  check("ctrl_after_rst", d, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
